bcd_timer_n: RTL and testbench
==============================

BCD_TIMER_N -- requirements
Module: bcd_timer_n

Interface
REQ-001 SHALL have parameter CLK_HZ, default 5000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1, meaning count rate in Hz; CLK_HZ/TICK_HZ SHALL be an integer >= 2.
REQ-003 SHALL have parameter DIGITS, default 2, meaning number of BCD digits, legal range 1..8.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: level, requests counting.
REQ-007 SHALL have port stop, input, 1 bit: level, requests pause.
REQ-008 SHALL have port clr, input, 1 bit: synchronous clear.
REQ-009 SHALL have port dir, input, 1 bit: 0 = count up, 1 = count down.
REQ-010 SHALL have port lap, input, 1 bit: one-cycle pulse that toggles display freeze.
REQ-011 SHALL have port seg, output, 7*DIGITS bits: per-digit active-low segments; digit k occupies bits [7k+6:7k], with bit 0 = a ... bit 6 = g; digit 0 is least significant.
REQ-012 SHALL have port running, output, 1 bit: high in state RUN.
REQ-013 SHALL have port wrap, output, 1 bit: one-cycle pulse on up-count rollover.
REQ-014 SHALL have port done, output, 1 bit: high in state DONE.

Function
REQ-015 SHALL define DIV = CLK_HZ/TICK_HZ and implement a prescaler counting 0..DIV-1; tick SHALL be high for the one cycle in which prescaler = DIV-1.
REQ-016 SHALL advance the prescaler only in RUN; it SHALL hold its value in PAUSE and be zeroed in IDLE and DONE.
REQ-017 SHALL implement states IDLE, RUN, PAUSE and DONE; IDLE SHALL be the reset state.
REQ-018 SHALL make these transitions: IDLE/PAUSE -> RUN on start & ~stop; RUN -> PAUSE on stop; DONE -> RUN on start & ~stop & dir = 0.
REQ-019 SHALL, when start and stop are both high, give stop priority: RUN goes to PAUSE and the other states hold.
REQ-020 SHALL, on clr, force IDLE, set the count to all zeros, zero the prescaler and release the lap freeze; clr SHALL override start, stop, lap and tick in the same cycle.
REQ-021 SHALL hold the count as DIGITS BCD digits, each in the range 0..9, and SHALL change the count only on tick in RUN.
REQ-022 SHALL, on an up tick, increment with decimal carry; at all-nines the count SHALL become all zeros and wrap SHALL pulse for exactly that cycle.
REQ-023 SHALL, on a down tick, decrement with decimal borrow; when the result is all zeros the state SHALL become DONE and the count SHALL hold at zero.
REQ-024 SHALL, when a down tick occurs in RUN with the count already zero, go to DONE without changing the count.
REQ-025 SHALL sample dir every cycle; a dir change SHALL take effect on the next tick and SHALL NOT reset the prescaler.
REQ-026 SHALL, on each lap pulse in any state other than IDLE, toggle the freeze flag; when the flag sets, the current count SHALL be copied into a display register.
REQ-027 SHALL drive seg from the display register while frozen and from the live count otherwise; seg SHALL be a combinational decode with zero-cycle latency.
REQ-028 SHALL use these active-low codes for digits 0..9: 40,79,24,30,19,12,02,78,00,10 (hex, g..a).
REQ-029 SHALL keep counting while the display is frozen.

Reset
REQ-030 SHALL, while rst is high, asynchronously force: state IDLE, count 0, prescaler 0, freeze flag cleared, display register 0, running=0, wrap=0, done=0, and seg = all digits showing 0x40.
REQ-031 SHALL, on reset assertion mid-RUN, abandon the pending tick, and SHALL resume counting only after rst deasserts and start is given.

Verification (CLK_HZ=10, TICK_HZ=1, DIGITS=2)
REQ-032 SHALL verify: rst, then start for 1 cycle, then wait 10 cycles -> running=1 and count 01 with seg = {0x40,0x79}; after 100 ticks total -> count 00 and one wrap pulse.
REQ-033 SHALL verify: start and stop held high together in IDLE -> state stays IDLE; stop at count 05 mid-prescaler -> count holds 05, and after start the next tick lands exactly at the remaining prescaler distance.
REQ-034 SHALL verify: dir=1 from count 03 -> count steps 02, 01, 00 on ticks, done=1 and running=0 at the 00 step, and the count stays 00 for 30 further cycles.
REQ-035 SHALL verify: lap at count 12 -> seg shows 12 while the count reaches 15; a second lap -> seg shows 15 in the same cycle.
REQ-036 SHALL verify: clr asserted in the same cycle as a tick at count 09 -> count 00, state IDLE and wrap=0.
REQ-037 SHALL verify: rst pulsed asynchronously mid-RUN at count 47 -> all outputs at their reset values with no wait for a clk edge.

Source files
------------

// File: rtl/bcd_timer_n.sv
// bcd_timer_n: prescaled BCD up/down timer with pause, lap freeze and 7-segment decode
module bcd_timer_n #(
  parameter int CLK_HZ = 5000000,
  parameter int TICK_HZ = 1,
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                clr,
  input  logic                dir,
  input  logic                lap,
  output logic [7*DIGITS-1:0] seg,
  output logic                running,
  output logic                wrap,
  output logic                done
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW = $clog2(DIV);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]          r_state;
  logic [PW-1:0]       r_pre;
  logic [4*DIGITS-1:0] r_cnt;
  logic [4*DIGITS-1:0] r_disp;
  logic                r_frz;
  logic                r_wrap;
  logic [1:0]          w_next;
  logic [4*DIGITS-1:0] w_inc;
  logic [4*DIGITS-1:0] w_dec;
  logic [4*DIGITS-1:0] w_show;
  logic                w_carry;
  logic                w_borrow;
  logic                w_tick;
  logic                w_go;
  logic                w_zero;
  logic                w_dec_zero;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  assign w_tick = (r_state == S_RUN) && (r_pre == PW'(DIV - 1));
  assign w_go = start & ~stop;
  assign w_zero = (r_cnt == '0);
  assign w_dec_zero = (w_dec == '0);
  assign w_show = r_frz ? r_disp : r_cnt;
  assign running = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign wrap = r_wrap;

  // Decimal increment and decrement of the live count, ripple carry/borrow digit by digit
  always_comb begin
    w_inc = r_cnt;
    w_dec = r_cnt;
    w_carry = 1'b1;
    w_borrow = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (w_carry) begin
        w_inc[4*k+:4] = (r_cnt[4*k+:4] == 4'd9) ? 4'd0 : r_cnt[4*k+:4] + 4'd1;
        w_carry = (r_cnt[4*k+:4] == 4'd9);
      end
      if (w_borrow) begin
        w_dec[4*k+:4] = (r_cnt[4*k+:4] == 4'd0) ? 4'd9 : r_cnt[4*k+:4] - 4'd1;
        w_borrow = (r_cnt[4*k+:4] == 4'd0);
      end
    end
  end

  // Next state; stop always wins over start, a down tick reaching or sitting at zero ends the run
  always_comb begin
    w_next = (r_state == S_RUN)  ? (stop ? S_PAUSE : (w_tick & dir & (w_zero | w_dec_zero)) ? S_DONE : S_RUN) :
             (r_state == S_DONE) ? ((w_go & ~dir) ? S_RUN : S_DONE) :
             (w_go ? S_RUN : r_state);
  end

  // State, prescaler, count, wrap pulse and lap freeze; clr overrides everything but reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pre <= '0;
      r_cnt <= '0;
      r_disp <= '0;
      r_frz <= 1'b0;
      r_wrap <= 1'b0;
    end else if (clr) begin
      r_state <= S_IDLE;
      r_pre <= '0;
      r_cnt <= '0;
      r_frz <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pre <= (r_state == S_RUN) ? (w_tick ? '0 : r_pre + 1'b1) : (r_state == S_PAUSE) ? r_pre : '0;
      r_wrap <= w_tick & ~dir & w_carry;
      if (w_tick) r_cnt <= dir ? (w_zero ? r_cnt : w_dec) : w_inc;
      if (lap && r_state != S_IDLE) begin
        r_frz <= ~r_frz;
        if (!r_frz) r_disp <= r_cnt;
      end
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_seg
    assign seg[7*k+:7] = dec7(w_show[4*k+:4]);
  end
endmodule

// File: tb/tb_bcd_timer_n.sv
// tb_bcd_timer_n: directed checks of the BCD timer at CLK_HZ=10, TICK_HZ=1, DIGITS=2
module tb_bcd_timer_n;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, clr = 1'b0, dir = 1'b0, lap = 1'b0;
  logic [13:0] seg;
  logic running, wrap, done;
  int n_chk = 0, n_err = 0;

  bcd_timer_n #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .dir(dir), .lap(lap),
    .seg(seg), .running(running), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] code(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      default: return 7'h10;
    endcase
  endfunction

  function automatic logic [13:0] es(input int v);
    return {code(v / 10), code(v % 10)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  initial begin
    #1;
    chk("rst_seg", 32'(seg), 32'h2040);
    chk("rst_running", 32'(running), 0);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_done", 32'(done), 0);
    cyc(2);
    rst = 1'b0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(10);
    chk("first_tick_seg", 32'(seg), 32'(es(1)));
    chk("first_tick_running", 32'(running), 1);
    cyc(980);
    chk("count99", 32'(seg), 32'(es(99)));
    cyc(9);
    chk("pre_wrap_low", 32'(wrap), 0);
    cyc(1);
    chk("wrap_seg", 32'(seg), 32'(es(0)));
    chk("wrap_pulse", 32'(wrap), 1);
    cyc(1);
    chk("wrap_one_cycle", 32'(wrap), 0);

    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr_running", 32'(running), 0);
    chk("clr_seg", 32'(seg), 32'(es(0)));
    start = 1'b1;
    stop = 1'b1;
    cyc(3);
    chk("start_stop_idle", 32'(running), 0);
    stop = 1'b0;
    cyc(1);
    start = 1'b0;
    cyc(53);
    chk("count05", 32'(seg), 32'(es(5)));
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    cyc(20);
    chk("pause_seg", 32'(seg), 32'(es(5)));
    chk("pause_running", 32'(running), 0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("resume_running", 32'(running), 1);
    cyc(5);
    chk("resume_before_tick", 32'(seg), 32'(es(5)));
    cyc(1);
    chk("resume_tick", 32'(seg), 32'(es(6)));

    dir = 1'b1;
    cyc(30);
    chk("down03", 32'(seg), 32'(es(3)));
    cyc(10);
    chk("down02", 32'(seg), 32'(es(2)));
    cyc(10);
    chk("down01", 32'(seg), 32'(es(1)));
    chk("down01_running", 32'(running), 1);
    cyc(10);
    chk("down00", 32'(seg), 32'(es(0)));
    chk("done_set", 32'(done), 1);
    chk("done_not_running", 32'(running), 0);
    chk("down_no_wrap", 32'(wrap), 0);
    cyc(30);
    chk("done_hold_seg", 32'(seg), 32'(es(0)));
    chk("done_hold", 32'(done), 1);

    dir = 1'b0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("done_restart", 32'(running), 1);
    cyc(120);
    chk("count12", 32'(seg), 32'(es(12)));
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    cyc(29);
    chk("frozen12", 32'(seg), 32'(es(12)));
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    chk("unfrozen15", 32'(seg), 32'(es(15)));

    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(99);
    chk("count09", 32'(seg), 32'(es(9)));
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr_tick_seg", 32'(seg), 32'(es(0)));
    chk("clr_tick_running", 32'(running), 0);
    chk("clr_tick_wrap", 32'(wrap), 0);
    chk("clr_tick_done", 32'(done), 0);
    cyc(10);
    chk("clr_idle_hold", 32'(seg), 32'(es(0)));

    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(450);
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    cyc(20);
    chk("frozen45", 32'(seg), 32'(es(45)));
    chk("run47_running", 32'(running), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_seg", 32'(seg), 32'h2040);
    chk("async_rst_running", 32'(running), 0);
    chk("async_rst_wrap", 32'(wrap), 0);
    chk("async_rst_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(20);
    chk("post_rst_idle", 32'(running), 0);
    chk("post_rst_seg", 32'(seg), 32'(es(0)));
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(10);
    chk("post_rst_tick", 32'(seg), 32'(es(1)));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
